// File: rtl/uart_tx_drain_if.sv
// Read-side handshake between a registered-output sync FIFO and its single consumer.
// master = the consumer (pops), slave = the FIFO (supplies data and the empty flag).
interface uart_tx_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that autonomously drains a registered-output FIFO.
// Each byte is popped, captured one cycle later and shifted out LSB-first on tx.
module uart_tx_drain #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enable,
  uart_tx_drain_if.master fifo,
  output logic            tx,
  output logic            busy,
  output logic            byte_done
);

  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_drain: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable && !fifo.fifo_empty) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (cnt_zero) state_d = S_DATA;
      S_DATA:  if (cnt_zero && (bit_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (cnt_zero) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: baud counter, bit index, shift register and the tx flop
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    case (state_q)
      S_LOAD: begin
        shift_d = fifo.fifo_dout;
        cnt_d   = CNT_RELOAD;
      end
      S_START, S_DATA, S_STOP: begin
        if (cnt_zero) begin
          cnt_d = CNT_RELOAD;
          if (state_q == S_START) begin
            bit_d = 3'd0;
          end else if (state_q == S_DATA) begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: ;
    endcase
    // tx is registered, so its next level follows the state being entered
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Outputs decoded from state
  always_comb begin
    fifo.fifo_rd_en = (state_q == S_FETCH);
    busy            = (state_q != S_IDLE);
    byte_done       = (state_q == S_STOP) && cnt_zero;
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: a queue-based FIFO model feeds the DUT, every output is logged
// per cycle, and frames are checked against an ideal 8N1 waveform and a mid-bit decoder.
module tb_uart_tx_drain;
  localparam int CLK_HZ  = 1000000;
  localparam int BAUD    = 100000;
  localparam int CPB     = 10;
  localparam int FRAME   = 10 * CPB;
  localparam int LOG_MAX = 4096;

  logic clk    = 1'b0;
  logic rstn   = 1'b0;
  logic enable = 1'b0;
  logic tx, busy, byte_done;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_tx_drain_if fif ();

  uart_tx_drain #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .fifo      (fif),
    .tx        (tx),
    .busy      (busy),
    .byte_done (byte_done)
  );

  // Behavioural sync FIFO, depth 16, registered dout
  logic [7:0] fq[$];
  logic       wr_en        = 1'b0;
  logic [7:0] wr_data      = 8'h00;
  logic       flush        = 1'b0;
  logic       fifo_empty_r = 1'b1;
  logic [7:0] fifo_dout_r  = 8'h00;
  assign fif.fifo_empty = fifo_empty_r;
  assign fif.fifo_dout  = fifo_dout_r;

  always @(posedge clk) begin
    if (flush) begin
      fq.delete();
    end else begin
      if (fif.fifo_rd_en && fq.size() > 0) fifo_dout_r <= fq.pop_front();
      if (wr_en && fq.size() < 16) fq.push_back(wr_data);
    end
    fifo_empty_r <= (fq.size() == 0);
  end

  // Per-cycle log of DUT outputs, sampled mid-cycle
  logic tx_log   [LOG_MAX];
  logic rd_log   [LOG_MAX];
  logic busy_log [LOG_MAX];
  logic bd_log   [LOG_MAX];
  int   log_n  = 0;
  bit   log_on = 1'b0;

  always @(negedge clk) begin
    if (log_on && log_n < LOG_MAX) begin
      tx_log[log_n]   = tx;
      rd_log[log_n]   = fif.fifo_rd_en;
      busy_log[log_n] = busy;
      bd_log[log_n]   = byte_done;
      log_n++;
    end
  end

  task automatic start_log();
    @(posedge clk);
    #1;
    log_n  = 0;
    log_on = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_tx_low(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit && !ok; c++) begin
      @(negedge clk);
      #1;
      if (tx === 1'b0) ok = 1'b1;
    end
  endtask

  function automatic int first_fall(input int from);
    for (int i = from; i < log_n; i++) if (tx_log[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int first_rd(input int from);
    for (int i = from; i < log_n; i++) if (rd_log[i] === 1'b1) return i;
    return -1;
  endfunction

  // which: 0 = fifo_rd_en, 1 = busy, 2 = byte_done, 3 = tx low
  function automatic int count_hi(input int which, input int from, input int to);
    int n = 0;
    for (int i = from; i < to && i < log_n; i++) begin
      case (which)
        0: if (rd_log[i] === 1'b1) n++;
        1: if (busy_log[i] === 1'b1) n++;
        2: if (bd_log[i] === 1'b1) n++;
        default: if (tx_log[i] !== 1'b1) n++;
      endcase
    end
    return n;
  endfunction

  // Ideal 8N1 frame: start 0, data LSB first, stop 1, each level CPB cycles
  function automatic int frame_errs(input int start, input logic [7:0] b);
    int   e = 0;
    int   bp;
    logic lvl;
    for (int k = 0; k < FRAME; k++) begin
      bp  = k / CPB;
      lvl = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : b[bp-1];
      if (start + k >= log_n) e++;
      else if (tx_log[start + k] !== lvl) e++;
    end
    return e;
  endfunction

  function automatic logic [7:0] decode(input int start);
    logic [7:0] b = 8'h00;
    int idx;
    for (int i = 0; i < 8; i++) begin
      idx = start + CPB * (i + 1) + CPB / 2;
      if (idx < log_n) b[i] = tx_log[idx];
    end
    return b;
  endfunction

  task automatic test_reset();
    rstn   = 1'b0;
    enable = 1'b1;
    wait_cycles(3);
    nchk++; if (tx !== 1'b1) begin nerr++; $display("FAIL reset_tx got=%b exp=1", tx); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", busy); end
    nchk++; if (fif.fifo_rd_en !== 1'b0) begin nerr++; $display("FAIL reset_rd_en got=%b exp=0", fif.fifo_rd_en); end
    nchk++; if (byte_done !== 1'b0) begin nerr++; $display("FAIL reset_byte_done got=%b exp=0", byte_done); end
    @(posedge clk);
    #1 rstn = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_idle_empty();
    enable = 1'b1;
    start_log();
    wait_cycles(500);
    nchk++; if (count_hi(3, 0, log_n) != 0) begin nerr++; $display("FAIL idle_tx_low cycles got=%0d exp=0", count_hi(3, 0, log_n)); end
    nchk++; if (count_hi(0, 0, log_n) != 0) begin nerr++; $display("FAIL idle_rd_en pulses got=%0d exp=0", count_hi(0, 0, log_n)); end
    nchk++; if (count_hi(1, 0, log_n) != 0) begin nerr++; $display("FAIL idle_busy cycles got=%0d exp=0", count_hi(1, 0, log_n)); end
    nchk++; if (count_hi(2, 0, log_n) != 0) begin nerr++; $display("FAIL idle_byte_done got=%0d exp=0", count_hi(2, 0, log_n)); end
    $display("test_idle_empty: %0d cycles observed", log_n);
  endtask

  task automatic test_single_a5();
    int r, f;
    enable = 1'b1;
    start_log();
    push_byte(8'hA5);
    wait_cycles(200);
    r = first_rd(0);
    f = first_fall(0);
    nchk++; if (count_hi(0, 0, log_n) != 1) begin nerr++; $display("FAIL a5_rd_pulses got=%0d exp=1", count_hi(0, 0, log_n)); end
    nchk++;
    if (r < 0 || f < 0 || f != r + 2) begin
      nerr++; $display("FAIL a5_latency rd_at=%0d fall_at=%0d exp_fall=rd+2", r, f);
    end else begin
      nchk++; if (frame_errs(f, 8'hA5) != 0) begin nerr++; $display("FAIL a5_waveform bad_cycles=%0d exp=0", frame_errs(f, 8'hA5)); end
      nchk++; if (bd_log[f + FRAME - 1] !== 1'b1) begin nerr++; $display("FAIL a5_byte_done_pos got=%b exp=1 at frame cycle %0d", bd_log[f + FRAME - 1], FRAME); end
    end
    nchk++; if (count_hi(2, 0, log_n) != 1) begin nerr++; $display("FAIL a5_byte_done_count got=%0d exp=1", count_hi(2, 0, log_n)); end
    nchk++; if (count_hi(1, 0, log_n) != FRAME + 2) begin nerr++; $display("FAIL a5_busy_cycles got=%0d exp=%0d", count_hi(1, 0, log_n), FRAME + 2); end
    $display("test_single_a5: rd_at=%0d fall_at=%0d byte=%h", r, f, (f >= 0) ? decode(f) : 8'hxx);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    int f, nf;
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(exp_b[i]);
    start_log();
    enable = 1'b1;
    wait_cycles(400);
    f = first_fall(0);
    for (int k = 0; k < 3; k++) begin
      nchk++;
      if (f < 0) begin
        nerr++; $display("FAIL b2b_frame%0d missing", k);
      end else begin
        if (decode(f) !== exp_b[k] || frame_errs(f, exp_b[k]) != 0) begin
          nerr++; $display("FAIL b2b_frame%0d got=%h exp=%h bad_cycles=%0d", k, decode(f), exp_b[k], frame_errs(f, exp_b[k]));
        end
        $display("test_back_to_back: frame %0d at %0d byte=%h", k, f, decode(f));
        nf = first_fall(f + FRAME);
        if (k < 2) begin
          nchk++; if (nf != f + FRAME + 3) begin nerr++; $display("FAIL b2b_gap%0d next_fall=%0d exp=%0d", k, nf, f + FRAME + 3); end
        end
        f = nf;
      end
    end
    nchk++; if (count_hi(0, 0, log_n) != 3) begin nerr++; $display("FAIL b2b_rd_pulses got=%0d exp=3", count_hi(0, 0, log_n)); end
    nchk++; if (fif.fifo_empty !== 1'b1) begin nerr++; $display("FAIL b2b_fifo_empty got=%b exp=1", fif.fifo_empty); end
  endtask

  task automatic test_fill_16();
    int f, r0, last_bd;
    enable = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    start_log();
    enable = 1'b1;
    wait_cycles(16 * (FRAME + 3) + 60);
    f = first_fall(0);
    last_bd = -1;
    for (int k = 0; k < 16; k++) begin
      nchk++;
      if (f < 0 || decode(f) !== 8'(k) || frame_errs(f, 8'(k)) != 0) begin
        nerr++; $display("FAIL fill16_frame%0d at=%0d got=%h exp=%h", k, f, (f >= 0) ? decode(f) : 8'hxx, 8'(k));
        break;
      end
      last_bd = f + FRAME - 1;
      f = first_fall(f + FRAME);
    end
    $display("test_fill_16: last byte_done at %0d", last_bd);
    r0 = first_rd(0);
    nchk++;
    if (r0 < 0 || last_bd < 0 || (last_bd - r0 + 1) - count_hi(1, r0, last_bd + 1) != 15) begin
      nerr++; $display("FAIL fill16_busy_gaps low_cycles=%0d exp=15", (last_bd - r0 + 1) - count_hi(1, r0, last_bd + 1));
    end
    nchk++; if (count_hi(2, 0, log_n) != 16) begin nerr++; $display("FAIL fill16_byte_done got=%0d exp=16", count_hi(2, 0, log_n)); end
  endtask

  task automatic test_enable_drop();
    logic [7:0] b0, b1;
    bit ok;
    int idx, f0, f1;
    b0 = 8'($urandom); b1 = 8'($urandom);
    enable = 1'b0;
    push_byte(b0);
    push_byte(b1);
    start_log();
    enable = 1'b1;
    wait_tx_low(50, ok);
    nchk++;
    if (!ok) begin
      nerr++; $display("FAIL drop_start timeout waiting for start bit");
    end else begin
      wait_cycles(45);
      @(posedge clk);
      #1 enable = 1'b0;
      wait_cycles(250);
      @(posedge clk);
      #1;
      idx = log_n;
      enable = 1'b1;
      wait_cycles(150);
      f0 = first_fall(0);
      nchk++; if (f0 < 0 || frame_errs(f0, b0) != 0) begin nerr++; $display("FAIL drop_frame1 got=%h exp=%h", (f0 >= 0) ? decode(f0) : 8'hxx, b0); end
      nchk++; if (count_hi(0, 0, idx) != 1) begin nerr++; $display("FAIL drop_rd_while_disabled got=%0d exp=1", count_hi(0, 0, idx)); end
      nchk++; if (count_hi(2, 0, idx) != 1) begin nerr++; $display("FAIL drop_byte_done1 got=%0d exp=1", count_hi(2, 0, idx)); end
      f1 = (f0 >= 0) ? first_fall(f0 + FRAME) : -1;
      nchk++; if (f1 != idx + 3) begin nerr++; $display("FAIL drop_resume_latency fall=%0d exp=%0d", f1, idx + 3); end
      nchk++; if (f1 < 0 || frame_errs(f1, b1) != 0) begin nerr++; $display("FAIL drop_frame2 got=%h exp=%h", (f1 >= 0) ? decode(f1) : 8'hxx, b1); end
      $display("test_enable_drop: b0=%h b1=%h resume_at=%0d fall2=%0d", b0, b1, idx, f1);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int f;
    enable = 1'b1;
    start_log();
    push_byte(8'h3C);
    wait_tx_low(50, ok);
    nchk++;
    if (!ok) begin
      nerr++; $display("FAIL rstmid_start timeout waiting for start bit");
    end else begin
      wait_cycles(12);
      nchk++; if (tx !== 1'b0) begin nerr++; $display("FAIL rstmid_data_bit0 got=%b exp=0", tx); end
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      nchk++; if (tx !== 1'b1) begin nerr++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
      nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      wait_cycles(5);
      nchk++; if (count_hi(2, 0, log_n) != 0) begin nerr++; $display("FAIL rstmid_byte_done got=%0d exp=0", count_hi(2, 0, log_n)); end
      @(negedge clk) flush = 1'b1;
      @(negedge clk) flush = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
      start_log();
      push_byte(8'h81);
      wait_cycles(200);
      f = first_fall(0);
      nchk++; if (f < 0 || frame_errs(f, 8'h81) != 0) begin nerr++; $display("FAIL rstmid_after got=%h exp=81", (f >= 0) ? decode(f) : 8'hxx); end
      nchk++; if (count_hi(2, 0, log_n) != 1) begin nerr++; $display("FAIL rstmid_after_byte_done got=%0d exp=1", count_hi(2, 0, log_n)); end
      $display("test_reset_midframe: frame after reset at %0d byte=%h", f, (f >= 0) ? decode(f) : 8'hxx);
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] sb[$];
    logic [7:0] b, e;
    int f;
    enable = 1'b1;
    start_log();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      push_byte(b);
      sb.push_back(b);
      wait_cycles($urandom_range(0, 120));
    end
    wait_cycles(800);
    f = first_fall(0);
    for (int k = 0; k < 6; k++) begin
      e = sb.pop_front();
      nchk++;
      if (f < 0 || decode(f) !== e || frame_errs(f, e) != 0) begin
        nerr++; $display("FAIL rand_frame%0d at=%0d got=%h exp=%h", k, f, (f >= 0) ? decode(f) : 8'hxx, e);
        break;
      end
      $display("test_random_stream: frame %0d at %0d byte=%h", k, f, e);
      f = first_fall(f + FRAME);
    end
    nchk++; if (count_hi(0, 0, log_n) != 6) begin nerr++; $display("FAIL rand_rd_pulses got=%0d exp=6", count_hi(0, 0, log_n)); end
    nchk++; if (count_hi(2, 0, log_n) != 6) begin nerr++; $display("FAIL rand_byte_done got=%0d exp=6", count_hi(2, 0, log_n)); end
  endtask

  initial begin
    test_reset();
    test_idle_empty();
    test_single_a5();
    test_back_to_back();
    test_fill_16();
    test_enable_drop();
    test_reset_midframe();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
